// File: rtl/cheshire_eoc_mailbox.sv
// cheshire_eoc_mailbox
// End-of-computation mailbox for the simulation SoC fixture. Software writes
// its exit status to a small register window. The block turns that write into
// a one-shot eoc_valid/exit_code handshake for the testbench top. A cycle
// watchdog forces TimeoutCode if software never reports.
//
// Register window (word aligned):
//   0x0 EOC     (W)  bit0 = done, [31:1] = code; reads give the captured exit code
//   0x4 STATUS  (RO) bit0 = eoc_valid, bit1 = timeout, bits[3:2] = FSM state
//   0x8 TIMEOUT (RW) watchdog limit in cycles, 0 disables expiry
//   0xC CTRL    (RW) bit0 = wdog_en, bit1 = clear (self-clearing, reads 0)
//
// Optional feature, macro CHESHIRE_EOC_HEARTBEAT_EN:
//   When defined, a TIMEOUT write with bit31 = 1 is a heartbeat. In ARMED it
//   restarts the counter and leaves TIMEOUT unchanged. A write with bit31 = 0
//   loads TIMEOUT[30:0], and bit31 of TIMEOUT always reads 0.
//   When undefined, TIMEOUT is a plain 32-bit register.

module cheshire_eoc_mailbox #(
    parameter int unsigned AddrWidth   = 4,
    parameter int unsigned CntWidth    = 32,
    parameter logic [31:0] TimeoutCode = 32'hDEAD_0001
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [31:0]          req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic                 eoc_valid_o,
    input  logic                 eoc_ready_i,
    output logic [31:0]          exit_code_o,
    output logic                 timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2,
        ACKED = 2'd3
    } state_e;

    // Word index inside the window; any bit above the 16 B window decodes as error.
    localparam int unsigned IdxWidth = AddrWidth - 2;
    localparam logic [IdxWidth-1:0] IDX_EOC     = IdxWidth'(0);
    localparam logic [IdxWidth-1:0] IDX_STATUS  = IdxWidth'(1);
    localparam logic [IdxWidth-1:0] IDX_TIMEOUT = IdxWidth'(2);
    localparam logic [IdxWidth-1:0] IDX_CTRL    = IdxWidth'(3);

    localparam logic [CntWidth-1:0] CNT_ZERO = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0] CNT_ONES = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] CNT_ONE  = CntWidth'(1);

    // Architectural state
    state_e                state_r;
    logic [31:0]           exit_code_r;
    logic                  timeout_flag_r;
    logic                  timeout_out_r;
    logic                  eoc_valid_r;
    logic [CntWidth-1:0]   wdog_cnt_r;
    logic [CntWidth-1:0]   timeout_lim_r;
    logic                  wdog_en_r;
    logic                  req_ready_r;

    // Response registers
    logic                  rsp_valid_r;
    logic [31:0]           rsp_rdata_r;
    logic                  rsp_error_r;

    // Decode and event signals
    logic                  xfer_s;
    logic [IdxWidth-1:0]   word_idx_s;
    logic [31:0]           status_s;
    logic [31:0]           rdata_s;
    logic                  dec_err_s;
    logic                  wr_eoc_s;
    logic                  wr_timeout_s;
    logic                  wr_ctrl_s;
    logic                  eoc_done_s;
    logic                  clear_s;
    logic                  arm_s;
    logic                  heartbeat_s;
    logic                  load_timeout_s;
    logic [CntWidth-1:0]   timeout_nxt_s;
    logic                  expire_s;
    logic [CntWidth-1:0]   cnt_inc_s;

    assign status_s = {28'h000_0000, state_r, timeout_flag_r, eoc_valid_r};

    // Address decode, read mux and per-register write strobes for an accepted request
    always_comb begin
        xfer_s       = req_valid_i && req_ready_r;
        word_idx_s   = req_addr_i[AddrWidth-1:2];
        rdata_s      = 32'h0000_0000;
        dec_err_s    = 1'b0;
        wr_eoc_s     = 1'b0;
        wr_timeout_s = 1'b0;
        wr_ctrl_s    = 1'b0;
        if (!xfer_s) begin
            dec_err_s = 1'b0;
        end else if (req_addr_i[1:0] != 2'b00) begin
            dec_err_s = 1'b1;
        end else begin
            case (word_idx_s)
                IDX_EOC: begin
                    if (req_write_i) begin
                        wr_eoc_s = 1'b1;
                    end else begin
                        rdata_s = exit_code_r;
                    end
                end
                IDX_STATUS: begin
                    if (req_write_i) begin
                        dec_err_s = 1'b1;
                    end else begin
                        rdata_s = status_s;
                    end
                end
                IDX_TIMEOUT: begin
                    if (req_write_i) begin
                        wr_timeout_s = 1'b1;
                    end else begin
                        rdata_s = 32'(timeout_lim_r);
                    end
                end
                IDX_CTRL: begin
                    if (req_write_i) begin
                        wr_ctrl_s = 1'b1;
                    end else begin
                        rdata_s = {31'h0000_0000, wdog_en_r};
                    end
                end
                default: begin
                    dec_err_s = 1'b1;
                end
            endcase
        end
    end

    // Derive FSM events from the write strobes and evaluate the watchdog
    always_comb begin
        eoc_done_s = wr_eoc_s && req_wdata_i[0];
        clear_s    = wr_ctrl_s && req_wdata_i[1];
        arm_s      = wr_ctrl_s && req_wdata_i[0];
`ifdef CHESHIRE_EOC_HEARTBEAT_EN
        heartbeat_s    = wr_timeout_s && req_wdata_i[31];
        load_timeout_s = wr_timeout_s && !req_wdata_i[31];
        timeout_nxt_s  = CntWidth'(req_wdata_i[30:0]);
`else
        heartbeat_s    = 1'b0;
        load_timeout_s = wr_timeout_s;
        timeout_nxt_s  = CntWidth'(req_wdata_i);
`endif
        // ">=" rather than "==" so a limit lowered below the running count expires next cycle
        expire_s = (state_r == ARMED) && (timeout_lim_r != CNT_ZERO) &&
                   (wdog_cnt_r >= (timeout_lim_r - CNT_ONE));
        if (wdog_cnt_r == CNT_ONES) begin
            cnt_inc_s = wdog_cnt_r;
        end else begin
            cnt_inc_s = wdog_cnt_r + CNT_ONE;
        end
    end

    // Mailbox FSM, watchdog counter, configuration registers and EOC handshake outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r        <= IDLE;
            exit_code_r    <= 32'h0000_0000;
            timeout_flag_r <= 1'b0;
            timeout_out_r  <= 1'b0;
            eoc_valid_r    <= 1'b0;
            wdog_cnt_r     <= CNT_ZERO;
            timeout_lim_r  <= CNT_ZERO;
            wdog_en_r      <= 1'b0;
            req_ready_r    <= 1'b0;
        end else begin
            req_ready_r <= 1'b1;
            if (load_timeout_s) begin
                timeout_lim_r <= timeout_nxt_s;
            end
            if (wr_ctrl_s) begin
                wdog_en_r <= req_wdata_i[0];
            end
            if (clear_s) begin
                state_r        <= IDLE;
                exit_code_r    <= 32'h0000_0000;
                timeout_flag_r <= 1'b0;
                timeout_out_r  <= 1'b0;
                eoc_valid_r    <= 1'b0;
                wdog_cnt_r     <= CNT_ZERO;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (eoc_done_s) begin
                            state_r        <= DONE;
                            exit_code_r    <= {1'b0, req_wdata_i[31:1]};
                            timeout_flag_r <= 1'b0;
                            timeout_out_r  <= 1'b0;
                            eoc_valid_r    <= 1'b1;
                        end else if (arm_s) begin
                            state_r    <= ARMED;
                            wdog_cnt_r <= CNT_ZERO;
                        end
                    end
                    ARMED: begin
                        // A software report beats a watchdog expiry in the same cycle
                        if (eoc_done_s) begin
                            state_r        <= DONE;
                            exit_code_r    <= {1'b0, req_wdata_i[31:1]};
                            timeout_flag_r <= 1'b0;
                            timeout_out_r  <= 1'b0;
                            eoc_valid_r    <= 1'b1;
                        end else if (heartbeat_s) begin
                            wdog_cnt_r <= CNT_ZERO;
                        end else if (expire_s) begin
                            state_r        <= DONE;
                            exit_code_r    <= TimeoutCode;
                            timeout_flag_r <= 1'b1;
                            timeout_out_r  <= 1'b1;
                            eoc_valid_r    <= 1'b1;
                        end else begin
                            wdog_cnt_r <= cnt_inc_s;
                        end
                    end
                    DONE: begin
                        if (eoc_ready_i) begin
                            state_r       <= ACKED;
                            eoc_valid_r   <= 1'b0;
                            timeout_out_r <= 1'b0;
                        end
                    end
                    ACKED: begin
                        state_r <= ACKED;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    // One-cycle response pulse carrying read data and decode status
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_error_r <= 1'b0;
        end else begin
            rsp_valid_r <= xfer_s;
            rsp_rdata_r <= rdata_s;
            rsp_error_r <= dec_err_s;
        end
    end

    assign req_ready_o = req_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_error_o = rsp_error_r;
    assign eoc_valid_o = eoc_valid_r;
    assign exit_code_o = exit_code_r;
    assign timeout_o   = timeout_out_r;

endmodule

// File: tb/tb_cheshire_eoc_mailbox.sv
// Directed testbench for cheshire_eoc_mailbox. Honours
// CHESHIRE_EOC_HEARTBEAT_EN the same way as the design.

module tb_cheshire_eoc_mailbox;

    localparam int unsigned AddrWidth = 4;
    localparam int unsigned CntWidth  = 32;

    localparam logic [3:0] A_EOC     = 4'h0;
    localparam logic [3:0] A_STATUS  = 4'h4;
    localparam logic [3:0] A_TIMEOUT = 4'h8;
    localparam logic [3:0] A_CTRL    = 4'hC;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_write_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [31:0]          req_wdata_i;
    logic                 rsp_valid_o;
    logic [31:0]          rsp_rdata_o;
    logic                 rsp_error_o;
    logic                 eoc_valid_o;
    logic                 eoc_ready_i;
    logic [31:0]          exit_code_o;
    logic                 timeout_o;

    int n_vec  = 0;
    int n_miss = 0;

    cheshire_eoc_mailbox #(
        .AddrWidth   (AddrWidth),
        .CntWidth    (CntWidth),
        .TimeoutCode (32'hDEAD_0001)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .eoc_valid_o (eoc_valid_o),
        .eoc_ready_i (eoc_ready_i),
        .exit_code_o (exit_code_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus transfer: drive on the falling edge, sample the response 1 ns after the accepting edge
    task automatic bus_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        rdata = rsp_rdata_o;
        err   = rsp_error_o;
        check_val("rsp_valid", 32'(rsp_valid_o), 32'h1);
    endtask

    task automatic ack_eoc();
        @(negedge clk_i);
        eoc_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        eoc_ready_i = 1'b0;
    endtask

    // Count cycles until eoc_valid_o rises; 0 means it never rose within the limit
    task automatic wait_eoc(input int limit, output int cycles);
        cycles = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk_i);
            #1;
            if (eoc_valid_o) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;

        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = 4'h0;
        req_wdata_i = 32'h0000_0000;
        eoc_ready_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_ready",  32'(req_ready_o), 32'h0);
        check_val("rst_rspv",   32'(rsp_valid_o), 32'h0);
        check_val("rst_eocv",   32'(eoc_valid_o), 32'h0);
        check_val("rst_code",   exit_code_o,      32'h0);
        check_val("rst_tmo",    32'(timeout_o),   32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_val("ready_up", 32'(req_ready_o), 32'h1);

        // EOC = 1: exit code 0, held stable until acknowledged
        bus_xfer(1'b1, A_EOC, 32'h0000_0001, rd, er);
        check_val("eoc1_err",  32'(er),          32'h0);
        check_val("eoc1_vld",  32'(eoc_valid_o), 32'h1);
        check_val("eoc1_code", exit_code_o,      32'h0);
        check_val("eoc1_tmo",  32'(timeout_o),   32'h0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            check_val("hold_vld",  32'(eoc_valid_o), 32'h1);
            check_val("hold_code", exit_code_o,      32'h0);
        end
        ack_eoc();
        check_val("ack_vld", 32'(eoc_valid_o), 32'h0);
        bus_xfer(1'b0, A_STATUS, 32'h0, rd, er);
        check_val("st_acked", rd, 32'h0000_000C);

        // Clear, EOC = 7 gives code 3; second EOC after ack is ignored without error
        bus_xfer(1'b1, A_CTRL, 32'h0000_0002, rd, er);
        bus_xfer(1'b0, A_STATUS, 32'h0, rd, er);
        check_val("st_idle", rd, 32'h0000_0000);
        bus_xfer(1'b1, A_EOC, 32'h0000_0007, rd, er);
        check_val("eoc7_code", exit_code_o,      32'h3);
        check_val("eoc7_vld",  32'(eoc_valid_o), 32'h1);
        ack_eoc();
        bus_xfer(1'b1, A_EOC, 32'h0000_0005, rd, er);
        check_val("eoc5_err",  32'(er),          32'h0);
        check_val("eoc5_code", exit_code_o,      32'h3);
        check_val("eoc5_vld",  32'(eoc_valid_o), 32'h0);
        bus_xfer(1'b0, A_EOC, 32'h0, rd, er);
        check_val("eoc_rd", rd, 32'h3);

        // Watchdog expiry 10 cycles after the CTRL response
        bus_xfer(1'b1, A_CTRL, 32'h0000_0002, rd, er);
        bus_xfer(1'b1, A_TIMEOUT, 32'd10, rd, er);
        bus_xfer(1'b0, A_TIMEOUT, 32'h0, rd, er);
        check_val("tmo_rd", rd, 32'd10);
        bus_xfer(1'b1, A_CTRL, 32'h0000_0001, rd, er);
        wait_eoc(20, cyc);
        check_val("wd_latency", 32'(cyc),        32'd10);
        check_val("wd_code",    exit_code_o,     32'hDEAD_0001);
        check_val("wd_tmo",     32'(timeout_o),  32'h1);
        bus_xfer(1'b0, A_STATUS, 32'h0, rd, er);
        check_val("st_wd", rd, 32'h0000_000B);
        ack_eoc();
        check_val("wd_ack_tmo", 32'(timeout_o), 32'h0);

        // EOC write lands in the expiry cycle: software wins
        bus_xfer(1'b1, A_CTRL, 32'h0000_0002, rd, er);
        bus_xfer(1'b1, A_TIMEOUT, 32'd10, rd, er);
        bus_xfer(1'b1, A_CTRL, 32'h0000_0001, rd, er);
        repeat (9) @(posedge clk_i);
        #1;
        check_val("race_pre_vld", 32'(eoc_valid_o), 32'h0);
        bus_xfer(1'b1, A_EOC, 32'h0000_0003, rd, er);
        check_val("race_vld",  32'(eoc_valid_o), 32'h1);
        check_val("race_code", exit_code_o,      32'h1);
        check_val("race_tmo",  32'(timeout_o),   32'h0);

        // Decode errors have no side effect; clear from DONE returns to IDLE
        bus_xfer(1'b0, 4'h2, 32'h0, rd, er);
        check_val("unal_err", 32'(er), 32'h1);
        check_val("unal_rd",  rd,      32'h0);
        bus_xfer(1'b1, A_STATUS, 32'hFFFF_FFFF, rd, er);
        check_val("wst_err",  32'(er),     32'h1);
        check_val("wst_code", exit_code_o, 32'h1);
        bus_xfer(1'b0, A_STATUS, 32'h0, rd, er);
        check_val("st_done", rd, 32'h0000_0009);
        bus_xfer(1'b1, A_CTRL, 32'h0000_0002, rd, er);
        check_val("clr_vld",  32'(eoc_valid_o), 32'h0);
        check_val("clr_code", exit_code_o,      32'h0);
        bus_xfer(1'b1, 4'h1, 32'h0000_0003, rd, er);
        check_val("unal_w_err", 32'(er),          32'h1);
        check_val("unal_w_vld", 32'(eoc_valid_o), 32'h0);

        // TIMEOUT = 0 never expires; lowering the limit below the count expires next cycle
        bus_xfer(1'b1, A_TIMEOUT, 32'd0, rd, er);
        bus_xfer(1'b1, A_CTRL, 32'h0000_0001, rd, er);
        repeat (30) @(posedge clk_i);
        #1;
        check_val("t0_vld", 32'(eoc_valid_o), 32'h0);
        bus_xfer(1'b1, A_TIMEOUT, 32'd5, rd, er);
        check_val("low_pre_vld", 32'(eoc_valid_o), 32'h0);
        @(posedge clk_i);
        #1;
        check_val("low_vld",  32'(eoc_valid_o), 32'h1);
        check_val("low_tmo",  32'(timeout_o),   32'h1);
        check_val("low_code", exit_code_o,      32'hDEAD_0001);
        bus_xfer(1'b1, A_CTRL, 32'h0000_0002, rd, er);

`ifdef CHESHIRE_EOC_HEARTBEAT_EN
        // Heartbeats every 8 cycles hold off expiry; expiry 10 cycles after the last one
        bus_xfer(1'b1, A_TIMEOUT, 32'd10, rd, er);
        bus_xfer(1'b1, A_CTRL, 32'h0000_0001, rd, er);
        for (int k = 0; k < 6; k++) begin
            repeat (7) @(posedge clk_i);
            bus_xfer(1'b1, A_TIMEOUT, 32'h8000_0000, rd, er);
            check_val("hb_vld", 32'(eoc_valid_o), 32'h0);
        end
        wait_eoc(20, cyc);
        check_val("hb_latency", 32'(cyc), 32'd10);
        bus_xfer(1'b0, A_TIMEOUT, 32'h0, rd, er);
        check_val("hb_tmo_rd", rd, 32'd10);
        bus_xfer(1'b1, A_CTRL, 32'h0000_0002, rd, er);
        bus_xfer(1'b1, A_TIMEOUT, 32'hFFFF_FFF0, rd, er);
        bus_xfer(1'b0, A_TIMEOUT, 32'h0, rd, er);
        check_val("hb_idle_rd", rd, 32'd10);
`else
        bus_xfer(1'b1, A_TIMEOUT, 32'h8000_000A, rd, er);
        bus_xfer(1'b0, A_TIMEOUT, 32'h0, rd, er);
        check_val("tmo32_rd", rd, 32'h8000_000A);
`endif

        // Asynchronous reset from DONE with a request in flight
        bus_xfer(1'b1, A_EOC, 32'h0000_0003, rd, er);
        check_val("pre_rst_vld", 32'(eoc_valid_o), 32'h1);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = A_STATUS;
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        #1;
        check_val("arst_rspv", 32'(rsp_valid_o), 32'h0);
        check_val("arst_vld",  32'(eoc_valid_o), 32'h0);
        check_val("arst_code", exit_code_o,      32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        bus_xfer(1'b0, A_STATUS, 32'h0, rd, er);
        check_val("arst_st", rd, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
